// File: rtl/bcd_down_timer_if.sv
// Control and display signals between the board switches/keys and the BCD countdown timer.
// The master side drives preset/load/run; the slave side is the timer itself.
interface bcd_down_timer_if;
    logic       load;
    logic [3:0] preset_tens;
    logic [3:0] preset_ones;
    logic       run;
    logic [3:0] tens_out;
    logic [3:0] ones_out;
    logic [6:0] seg7_tens;
    logic [6:0] seg7_ones;
    logic       busy;
    logic       done;

    modport master (
        output load, preset_tens, preset_ones, run,
        input  tens_out, ones_out, seg7_tens, seg7_ones, busy, done
    );

    modport slave (
        input  load, preset_tens, preset_ones, run,
        output tens_out, ones_out, seg7_tens, seg7_ones, busy, done
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Two-digit BCD countdown timer with a power-of-two tick prescaler, borrow from ones
// to tens, and registered active-low seven-segment outputs.
module bcd_down_timer #(
    parameter int DIV_EXP  = 22,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    bcd_down_timer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ARMED, RUNNING, DONE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    state_t               state_q, state_d;
    logic [3:0]           tens_q, tens_d;
    logic [3:0]           ones_q, ones_d;
    logic [DIV_EXP-1:0]   div_q, div_d;
    logic                 busy_q, done_q;
    logic [6:0]           seg7_tens_q, seg7_ones_q;
    logic                 tick;
    logic                 count_zero;
    logic                 dec_to_zero;

    function automatic logic [6:0] seg7_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg7_enc = 7'b1000000;
            4'd1:    seg7_enc = 7'b1111001;
            4'd2:    seg7_enc = 7'b0100100;
            4'd3:    seg7_enc = 7'b0110000;
            4'd4:    seg7_enc = 7'b0011001;
            4'd5:    seg7_enc = 7'b0010010;
            4'd6:    seg7_enc = 7'b0000010;
            4'd7:    seg7_enc = 7'b1111000;
            4'd8:    seg7_enc = 7'b0000000;
            4'd9:    seg7_enc = 7'b0010000;
            default: seg7_enc = 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] sat9(input logic [3:0] d);
        sat9 = (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign tick        = (state_q == RUNNING) && (div_q == '1);
    assign count_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign dec_to_zero = (tens_q == 4'd0) && (ones_q == 4'd1);

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        div_d   = div_q;
        if (bus.load) begin
            // A load overrides any tick in the same cycle.
            tens_d  = sat9(bus.preset_tens);
            ones_d  = sat9(bus.preset_ones);
            div_d   = '0;
            state_d = ARMED;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ARMED: begin
                    if (bus.run) state_d = RUNNING;
                end
                RUNNING: begin
                    div_d = div_q + DIV_EXP'(1);
                    if (count_zero) begin
                        state_d = DONE;
                    end else if (tick) begin
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end
                        if (dec_to_zero)  state_d = DONE;
                        else if (!bus.run) state_d = ARMED;
                    end else if (!bus.run) begin
                        // Pause keeps the divider so the resumed count keeps its phase.
                        state_d = ARMED;
                    end
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            div_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seg7_ones_q <= SEG_ZERO;
            seg7_tens_q <= BLANK_LZ ? SEG_BLANK : SEG_ZERO;
        end else begin
            state_q     <= state_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            div_q       <= div_d;
            busy_q      <= (state_d == RUNNING);
            done_q      <= (state_d == DONE);
            // Segments follow the digit registers by one cycle.
            seg7_ones_q <= seg7_enc(ones_q);
            seg7_tens_q <= (BLANK_LZ && (tens_q == 4'd0)) ? SEG_BLANK : seg7_enc(tens_q);
        end
    end

    assign bus.tens_out  = tens_q;
    assign bus.ones_out  = ones_q;
    assign bus.seg7_tens = seg7_tens_q;
    assign bus.seg7_ones = seg7_ones_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Self-checking bench for bcd_down_timer with DIV_EXP=2: table of timed input steps
// with expected outputs queued at drive time, plus a latency measurement sequence.
module tb_bcd_down_timer;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] S0 = 7'h40;
    localparam logic [6:0] S1 = 7'h79;
    localparam logic [6:0] S2 = 7'h24;
    localparam logic [6:0] S5 = 7'h12;
    localparam logic [6:0] S9 = 7'h10;

    logic clk;
    logic reset;

    bcd_down_timer_if bus();

    bcd_down_timer #(.DIV_EXP(2), .BLANK_LZ(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       ld;
        logic [3:0] pt;
        logic [3:0] po;
        logic       run;
        int         cyc;
        logic [3:0] et;
        logic [3:0] eo;
        logic       eb;
        logic       ed;
        logic [6:0] est;
        logic [6:0] eso;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(string name, logic rst, logic ld, logic [3:0] pt, logic [3:0] po,
                                logic run, int cyc, logic [3:0] et, logic [3:0] eo, logic eb,
                                logic ed, logic [6:0] est, logic [6:0] eso);
        vec_t v;
        v.name = name; v.rst = rst; v.ld = ld; v.pt = pt; v.po = po; v.run = run; v.cyc = cyc;
        v.et = et; v.eo = eo; v.eb = eb; v.ed = ed; v.est = est; v.eso = eso;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ld, input logic [3:0] pt,
                         input logic [3:0] po, input logic run);
        reset           = rst;
        bus.load        = ld;
        bus.preset_tens = pt;
        bus.preset_ones = po;
        bus.run         = run;
    endtask

    initial begin
        vec_t e;
        int   n;
        logic [3:0] prev;

        //            name           rst ld  pt     po     run cyc et    eo    eb ed est eso
        vecs.push_back(mk("reset",        1, 0, 4'd0, 4'd0, 0, 2,  4'd0, 4'd0, 0, 0, BL, S0));
        vecs.push_back(mk("idle",         0, 0, 4'd0, 4'd0, 0, 10, 4'd0, 4'd0, 0, 0, BL, S0));
        vecs.push_back(mk("run_in_idle",  0, 0, 4'd0, 4'd0, 1, 3,  4'd0, 4'd0, 0, 0, BL, S0));
        vecs.push_back(mk("ld12",         0, 1, 4'd1, 4'd2, 0, 1,  4'd1, 4'd2, 0, 0, BL, S0));
        vecs.push_back(mk("arm_run",      0, 0, 4'd0, 4'd0, 1, 1,  4'd1, 4'd2, 1, 0, S1, S2));
        vecs.push_back(mk("pre_tick",     0, 0, 4'd0, 4'd0, 1, 3,  4'd1, 4'd2, 1, 0, S1, S2));
        vecs.push_back(mk("dec_11",       0, 0, 4'd0, 4'd0, 1, 1,  4'd1, 4'd1, 1, 0, S1, S2));
        vecs.push_back(mk("seg_lag",      0, 0, 4'd0, 4'd0, 1, 1,  4'd1, 4'd1, 1, 0, S1, S1));
        vecs.push_back(mk("dec_10",       0, 0, 4'd0, 4'd0, 1, 3,  4'd1, 4'd0, 1, 0, S1, S1));
        vecs.push_back(mk("borrow_09",    0, 0, 4'd0, 4'd0, 1, 4,  4'd0, 4'd9, 1, 0, S1, S0));
        vecs.push_back(mk("blank_tens",   0, 0, 4'd0, 4'd0, 1, 1,  4'd0, 4'd9, 1, 0, BL, S9));
        vecs.push_back(mk("dec_08",       0, 0, 4'd0, 4'd0, 1, 3,  4'd0, 4'd8, 1, 0, BL, S9));
        vecs.push_back(mk("dec_01",       0, 0, 4'd0, 4'd0, 1, 28, 4'd0, 4'd1, 1, 0, BL, S2));
        vecs.push_back(mk("done_00",      0, 0, 4'd0, 4'd0, 1, 4,  4'd0, 4'd0, 0, 1, BL, S1));
        vecs.push_back(mk("done_hold",    0, 0, 4'd0, 4'd0, 1, 10, 4'd0, 4'd0, 0, 1, BL, S0));
        vecs.push_back(mk("ld03",         0, 1, 4'd0, 4'd3, 0, 1,  4'd0, 4'd3, 0, 0, BL, S0));
        vecs.push_back(mk("run6",         0, 0, 4'd0, 4'd0, 1, 6,  4'd0, 4'd2, 1, 0, BL, S2));
        vecs.push_back(mk("pause",        0, 0, 4'd0, 4'd0, 0, 20, 4'd0, 4'd2, 0, 0, BL, S2));
        vecs.push_back(mk("resume",       0, 0, 4'd0, 4'd0, 1, 2,  4'd0, 4'd2, 1, 0, BL, S2));
        vecs.push_back(mk("phase_kept",   0, 0, 4'd0, 4'd0, 1, 1,  4'd0, 4'd1, 1, 0, BL, S2));
        vecs.push_back(mk("sat_99",       0, 1, 4'hC, 4'hF, 0, 1,  4'd9, 4'd9, 0, 0, BL, S1));
        vecs.push_back(mk("sat_seg",      0, 0, 4'd0, 4'd0, 0, 1,  4'd9, 4'd9, 0, 0, S9, S9));
        vecs.push_back(mk("ld00",         0, 1, 4'd0, 4'd0, 0, 1,  4'd0, 4'd0, 0, 0, S9, S9));
        vecs.push_back(mk("zero_run",     0, 0, 4'd0, 4'd0, 1, 1,  4'd0, 4'd0, 1, 0, BL, S0));
        vecs.push_back(mk("zero_done",    0, 0, 4'd0, 4'd0, 1, 1,  4'd0, 4'd0, 0, 1, BL, S0));
        vecs.push_back(mk("ld05",         0, 1, 4'd0, 4'd5, 0, 1,  4'd0, 4'd5, 0, 0, BL, S0));
        vecs.push_back(mk("armed_05",     0, 0, 4'd0, 4'd0, 1, 4,  4'd0, 4'd5, 1, 0, BL, S5));
        vecs.push_back(mk("ld_on_tick",   0, 1, 4'd2, 4'd0, 1, 1,  4'd2, 4'd0, 0, 0, BL, S5));
        vecs.push_back(mk("ld_tick_hold", 0, 0, 4'd0, 4'd0, 0, 1,  4'd2, 4'd0, 0, 0, S2, S0));
        vecs.push_back(mk("run_pre_rst",  0, 0, 4'd0, 4'd0, 1, 3,  4'd2, 4'd0, 1, 0, S2, S0));
        vecs.push_back(mk("rst_mid",      1, 0, 4'd0, 4'd0, 1, 1,  4'd0, 4'd0, 0, 0, BL, S0));
        vecs.push_back(mk("rst_then_idle",0, 0, 4'd0, 4'd0, 1, 3,  4'd0, 4'd0, 0, 0, BL, S0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].pt, vecs[i].po, vecs[i].run);
            sb.push_back(vecs[i]);
            repeat (vecs[i].cyc) @(posedge clk);
            #1;
            e = sb.pop_front();
            chk({e.name, ".tens"},  int'(bus.tens_out),  int'(e.et));
            chk({e.name, ".ones"},  int'(bus.ones_out),  int'(e.eo));
            chk({e.name, ".busy"},  int'(bus.busy),      int'(e.eb));
            chk({e.name, ".done"},  int'(bus.done),      int'(e.ed));
            chk({e.name, ".seg_t"}, int'(bus.seg7_tens), int'(e.est));
            chk({e.name, ".seg_o"}, int'(bus.seg7_ones), int'(e.eso));
        end

        // Latency from run rising: first decrement after 5 edges, next after 4.
        drive(0, 1, 4'd0, 4'd2, 0);
        @(posedge clk); #1;
        drive(0, 0, 4'd0, 4'd0, 1);
        prev = bus.ones_out;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.ones_out == prev && n < 20);
        chk("lat_first", n, 5);
        chk("lat_first_val", int'(bus.ones_out), 1);
        prev = bus.ones_out;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.ones_out == prev && n < 20);
        chk("lat_next", n, 4);
        chk("lat_done", int'(bus.done), 1);
        chk("lat_busy", int'(bus.busy), 0);

        // Reset out of DONE clears done on the next edge.
        drive(1, 0, 4'd0, 4'd0, 0);
        @(posedge clk); #1;
        chk("rst_done.done", int'(bus.done), 0);
        drive(0, 0, 4'd0, 4'd0, 0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Two-digit BCD countdown timer; the counting complement of the team's 0-9 up-counter/carry chain.
- Counts down with a borrow from ones to tens, using an internal tick prescaler.
- Drives two active-low seven-segment digits (abcdefg, same glyph encoding as the team's BCD decoder) and a done flag.
- Sits between board switches/keys (preset, load, run) and the HEX displays.

Parameters:
- DIV_EXP, 22, prescaler width; one count tick every 2^DIV_EXP clk cycles spent in RUNNING.
- BLANK_LZ, 1, when 1 the tens digit is blanked (7'b1111111) while tens==0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  one-cycle pulse; captures preset digits
- preset_tens  in  4  BCD preset, tens digit
- preset_ones  in  4  BCD preset, ones digit
- run  in  1  level; 1 = count, 0 = pause
- tens_out  out  4  current tens digit
- ones_out  out  4  current ones digit
- seg7_tens  out  7  active-low segments, tens digit
- seg7_ones  out  7  active-low segments, ones digit
- busy  out  1  1 while state==RUNNING
- done  out  1  1 while state==DONE

Behaviour:
- All state updates occur on posedge clk. Priority order: reset > load > run/tick.
- Reset values:
  - state=IDLE, tens=0, ones=0, divider=0, busy=0, done=0.
  - seg7_ones=7'b1000000.
  - seg7_tens=7'b1111111 if BLANK_LZ, else 7'b1000000.
- Reset asserted mid-count aborts immediately; no partial tick is retained.
- States:
  - IDLE: holds 00. load -> ARMED. run is ignored.
  - ARMED: holds the count, divider frozen. run=1 -> RUNNING next edge.
  - RUNNING: divider increments each cycle. tick = (divider == all-ones) in RUNNING; the divider wraps to 0 on the same edge.
    - On tick, the count decrements. If the new value is 00, next state is DONE.
    - run=0 -> ARMED (pause). The divider value is kept, so a resumed count keeps its phase.
    - If run=0 and tick coincide, the decrement is taken and the state goes to ARMED (or DONE if the result is 00).
  - DONE: holds 00, done=1. run is ignored. Leaves only on load or reset.
- load in any state:
  - tens <= preset_tens and ones <= preset_ones; any digit >9 saturates to 9.
  - divider <= 0, state <= ARMED, done <= 0.
  - A load in the same cycle as a tick wins: the preset value is captured and no decrement is applied.
- Preset 00 then run=1: ARMED -> RUNNING, then DONE one cycle later without a tick. Count stays 00.
- Decrement rules:
  - ones != 0: ones-1.
  - ones == 0: ones=9 and tens-1 (borrow).
  - Never wraps below 00; DONE stops counting.
- Latency:
  - run rises in ARMED with divider=0: the first decrement is visible 1 + 2^DIV_EXP edges later.
  - Each subsequent decrement follows every 2^DIV_EXP cycles.
- Segment outputs:
  - Registered one cycle behind the digits, so segments change the edge after tens_out/ones_out.
  - Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other value gives 1111111.
  - BLANK_LZ applies to tens only; the ones digit always displays.
- busy and done are registered state decodes, mutually exclusive.

Test Plan:
- DIV_EXP=2 for all cases.
- Reset, then idle 10 cycles -> tens/ones=0/0, busy=0, done=0, seg7_ones=1000000, seg7_tens=1111111. Pulsing run alone does not change state.
- load 1/2, run=1 held -> tens/ones go 1/2 (preset), 1/1, 1/0, 0/9 (borrow) ... 0/1, 0/0, with exactly 4 cycles between decrements.
  - First decrement lands 5 edges after run rises.
  - done rises with 0/0; seg7_tens blanks when tens becomes 0.
- load 0/3, run high 6 cycles, run low 20 cycles, run high -> count holds at 0/2 during the pause, busy=0 while paused. The next decrement arrives with preserved divider phase.
- load with preset_tens=4'hC, preset_ones=4'hF -> tens/ones=9/9, seg7 shows 0010000 on both digits.
- load 0/0, run=1 -> DONE within 2 edges, no decrement, tens/ones stay 0/0, done=1. Then load 0/5 -> done=0, state ARMED.
- Coincidences:
  - load 2/0 on the exact tick cycle -> 2/0 is captured, no decrement.
  - reset asserted mid-run -> 0/0, IDLE, done=0 on the next edge.
